axi_rr_arbiter: RTL and testbench

//  Shares one downstream AXI slave port (ariane_axi::req_t/resp_t) between NumMst upstream masters.

---
 rtl/axi_rr_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter.sv
// Round-robin sharing of one AXI slave port between NumMst masters.
// Read and write paths each carry one transaction at a time.
package ariane_axi;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_t;

  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    b_t   b;
    logic b_valid;
    logic ar_ready;
    r_t   r;
    logic r_valid;
  } resp_t;
endpackage

module axi_rr_arbiter
  import ariane_axi::*;
#(
  parameter int NumMst = 2,
  parameter int IdxW   = $clog2(NumMst)
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  req_t  slv_req_i [NumMst],
  output resp_t slv_resp_o [NumMst],
  output req_t  mst_req_o,
  input  resp_t mst_resp_i,
  output logic  wr_busy_o,
  output logic  rd_busy_o
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_st_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_st_e;

  wr_st_e          wr_st, wr_nx;
  rd_st_e          rd_st, rd_nx;
  logic [IdxW-1:0] wgnt, wgnt_nx, rgnt, rgnt_nx;
  logic [IdxW-1:0] wr_prio, wr_prio_nx, rd_prio, rd_prio_nx;
  logic [NumMst-1:0] aw_req, ar_req;

  // First requester at or above prio, else lowest requester (wrap).
  function automatic logic [IdxW-1:0] rr_pick(
    input logic [NumMst-1:0] req,
    input logic [IdxW-1:0]   prio
  );
    logic [IdxW-1:0] pick;
    logic            found;
    pick  = prio;
    found = 1'b0;
    for (int i = 0; i < NumMst; i++) begin
      if (!found && req[i] && IdxW'(i) >= prio) begin
        pick  = IdxW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NumMst; i++) begin
      if (!found && req[i]) begin
        pick  = IdxW'(i);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IdxW-1:0] nxt(input logic [IdxW-1:0] g);
    return (g == IdxW'(NumMst - 1)) ? '0 : g + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NumMst; i++) begin
      aw_req[i] = slv_req_i[i].aw_valid;
      ar_req[i] = slv_req_i[i].ar_valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_st   <= W_IDLE;
      rd_st   <= R_IDLE;
      wgnt    <= '0;
      rgnt    <= '0;
      wr_prio <= '0;
      rd_prio <= '0;
    end else begin
      wr_st   <= wr_nx;
      rd_st   <= rd_nx;
      wgnt    <= wgnt_nx;
      rgnt    <= rgnt_nx;
      wr_prio <= wr_prio_nx;
      rd_prio <= rd_prio_nx;
    end
  end

  always_comb begin
    wr_nx      = wr_st;
    wgnt_nx    = wgnt;
    wr_prio_nx = wr_prio;
    unique case (wr_st)
      W_IDLE: if (|aw_req) begin
        wgnt_nx = rr_pick(aw_req, wr_prio);
        wr_nx   = W_ADDR;
      end
      W_ADDR: if (slv_req_i[wgnt].aw_valid && mst_resp_i.aw_ready)
        wr_nx = W_DATA;
      W_DATA: if (slv_req_i[wgnt].w_valid && mst_resp_i.w_ready
                  && slv_req_i[wgnt].w.last)
        wr_nx = W_RESP;
      W_RESP: if (mst_resp_i.b_valid && slv_req_i[wgnt].b_ready) begin
        wr_nx      = W_IDLE;
        wr_prio_nx = nxt(wgnt);
      end
    endcase
  end

  always_comb begin
    rd_nx      = rd_st;
    rgnt_nx    = rgnt;
    rd_prio_nx = rd_prio;
    unique case (rd_st)
      R_IDLE: if (|ar_req) begin
        rgnt_nx = rr_pick(ar_req, rd_prio);
        rd_nx   = R_ADDR;
      end
      R_ADDR: if (slv_req_i[rgnt].ar_valid && mst_resp_i.ar_ready)
        rd_nx = R_DATA;
      R_DATA: if (mst_resp_i.r_valid && slv_req_i[rgnt].r_ready
                  && mst_resp_i.r.last) begin
        rd_nx      = R_IDLE;
        rd_prio_nx = nxt(rgnt);
      end
      default: rd_nx = R_IDLE;
    endcase
  end

  // Payload follows the registered grant; handshakes are gated by state.
  always_comb begin
    for (int i = 0; i < NumMst; i++) begin
      slv_resp_o[i]   = '0;
      slv_resp_o[i].b = mst_resp_i.b;
      slv_resp_o[i].r = mst_resp_i.r;
    end
    mst_req_o    = '0;
    mst_req_o.aw = slv_req_i[wgnt].aw;
    mst_req_o.w  = slv_req_i[wgnt].w;
    mst_req_o.ar = slv_req_i[rgnt].ar;
    unique case (wr_st)
      W_ADDR: begin
        mst_req_o.aw_valid          = slv_req_i[wgnt].aw_valid;
        slv_resp_o[wgnt].aw_ready   = mst_resp_i.aw_ready;
      end
      W_DATA: begin
        mst_req_o.w_valid           = slv_req_i[wgnt].w_valid;
        slv_resp_o[wgnt].w_ready    = mst_resp_i.w_ready;
      end
      W_RESP: begin
        mst_req_o.b_ready           = slv_req_i[wgnt].b_ready;
        slv_resp_o[wgnt].b_valid    = mst_resp_i.b_valid;
      end
      default: ;
    endcase
    unique case (rd_st)
      R_ADDR: begin
        mst_req_o.ar_valid          = slv_req_i[rgnt].ar_valid;
        slv_resp_o[rgnt].ar_ready   = mst_resp_i.ar_ready;
      end
      R_DATA: begin
        mst_req_o.r_ready           = slv_req_i[rgnt].r_ready;
        slv_resp_o[rgnt].r_valid    = mst_resp_i.r_valid;
      end
      default: ;
    endcase
  end

  assign wr_busy_o = (wr_st != W_IDLE);
  assign rd_busy_o = (rd_st != R_IDLE);

`ifndef SYNTHESIS
  // A response with no transaction in flight is dropped, never routed.
  b_outside_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    mst_resp_i.b_valid |-> wr_st == W_RESP);
  r_outside_data: assert property (@(posedge clk_i) disable iff (rst_i)
    mst_resp_i.r_valid |-> rd_st == R_DATA);
`endif

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Bench for axi_rr_arbiter: bus agents plus a transaction-level
// reference model compared against the DUT every cycle.
module tb_axi_rr_arbiter;
  import ariane_axi::*;

  localparam int N = 3;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  req_t  sreq [N];
  resp_t sresp [N];
  req_t  mreq;
  resp_t mresp;
  logic  wbusy, rbusy;

  always #5 clk = ~clk;

  axi_rr_arbiter #(.NumMst(N)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slv_req_i  (sreq),
    .slv_resp_o (sresp),
    .mst_req_o  (mreq),
    .mst_resp_i (mresp),
    .wr_busy_o  (wbusy),
    .rd_busy_o  (rbusy)
  );

  int n_chk, n_fail;
  bit rst_cmd, rnd;
  int w_hold, r_hold;

  // upstream master agents
  int wq [N][$];
  int rq [N][$];
  bit wa [N], was [N], wv [N], wearly [N], early_next [N];
  int wl [N], wb [N], wseq [N];
  bit ra [N], ras [N];
  int rl [N], rb [N];
  logic [31:0] raddr [N];
  int b_cnt [N], r_cnt [N];

  // downstream slave agent
  bit s_w, s_b, s_r, s_rv;
  logic [3:0] s_wid, s_rid;
  logic [31:0] s_raddr;
  int s_wlen, s_wbeat, s_rlen, s_rbeat;

  // reference model: owner of each path and its progress
  int mw_own, mr_own, mw_prio, mr_prio;
  bit mw_aw, mw_w, mr_ar;
  int gq_w[$];
  int gq_r[$];

  // observation flags for directed checks
  bit m1_seen;
  int early_blk, early_bad;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit coin();
    return !rnd || ($urandom_range(1) == 1);
  endfunction

  function automatic int rr(input bit req [N], input int prio);
    for (int k = 0; k < N; k++)
      if (req[(prio + k) % N]) return (prio + k) % N;
    return -1;
  endfunction

  task automatic drive();
    rst = rst_cmd;
    for (int m = 0; m < N; m++) begin
      if (!wa[m] && wq[m].size() > 0
          && (!rnd || $urandom_range(2) == 0)) begin
        wa[m] = 1; was[m] = 0; wb[m] = 0; wv[m] = 0;
        wl[m] = wq[m].pop_front();
        wseq[m]++;
        wearly[m] = early_next[m] || (rnd && $urandom_range(3) == 0);
        early_next[m] = 0;
      end
      if (wa[m] && !wv[m] && wb[m] <= wl[m] && (was[m] || wearly[m]))
        wv[m] = coin();
      sreq[m].aw.id     = 4'(m);
      sreq[m].aw.addr   = 32'(m * 4096 + wseq[m]);
      sreq[m].aw.len    = 8'(wl[m]);
      sreq[m].aw_valid  = wa[m] && !was[m];
      sreq[m].w.data    = {4'(m), 12'(wseq[m]), 16'(wb[m])};
      sreq[m].w.strb    = 4'hf;
      sreq[m].w.last    = (wb[m] == wl[m]);
      sreq[m].w_valid   = wv[m];
      sreq[m].b_ready   = wa[m] && wb[m] > wl[m] && coin();
      if (!ra[m] && rq[m].size() > 0
          && (!rnd || $urandom_range(2) == 0)) begin
        ra[m] = 1; ras[m] = 0; rb[m] = 0;
        rl[m] = rq[m].pop_front();
        raddr[m] = $urandom;
      end
      sreq[m].ar.id     = 4'(m);
      sreq[m].ar.addr   = raddr[m];
      sreq[m].ar.len    = 8'(rl[m]);
      sreq[m].ar_valid  = ra[m] && !ras[m];
      sreq[m].r_ready   = ra[m] && ras[m] && r_hold == 0 && coin();
    end
    mresp          = '0;
    mresp.aw_ready = !s_w && coin();
    mresp.w_ready  = s_w && !s_b && w_hold == 0 && coin();
    mresp.b_valid  = s_b;
    mresp.b.id     = s_wid;
    mresp.ar_ready = !s_r && coin();
    if (s_r && !s_rv) s_rv = coin();
    mresp.r_valid  = s_rv;
    mresp.r.id     = s_rid;
    mresp.r.data   = s_raddr + 32'(s_rbeat);
    mresp.r.last   = (s_rbeat == s_rlen);
  endtask

  task automatic sample();
    int wo, ro;
    bit eawv, ewv, ebr, earv, err;
    bit req [N];
    logic [4:0] es;
    wo = mw_own; ro = mr_own;
    eawv = 0; ewv = 0; ebr = 0; earv = 0; err = 0;
    if (wo >= 0) begin
      eawv = !mw_aw && sreq[wo].aw_valid;
      ewv  = mw_aw && !mw_w && sreq[wo].w_valid;
      ebr  = mw_w && sreq[wo].b_ready;
    end
    if (ro >= 0) begin
      earv = !mr_ar && sreq[ro].ar_valid;
      err  = mr_ar && sreq[ro].r_ready;
    end
    chk("busy", 64'({wbusy, rbusy}), 64'({wo >= 0, ro >= 0}));
    chk("mst_ctl", 64'({mreq.aw_valid, mreq.w_valid, mreq.b_ready,
        mreq.ar_valid, mreq.r_ready}), 64'({eawv, ewv, ebr, earv, err}));
    if (eawv) chk("aw_pay", 64'(mreq.aw), 64'(sreq[wo].aw));
    if (ewv) chk("w_pay", 64'(mreq.w), 64'(sreq[wo].w));
    if (earv) chk("ar_pay", 64'(mreq.ar), 64'(sreq[ro].ar));
    for (int m = 0; m < N; m++) begin
      es = {m == wo && !mw_aw && mresp.aw_ready,
            m == wo && mw_aw && !mw_w && mresp.w_ready,
            m == wo && mw_w && mresp.b_valid,
            m == ro && !mr_ar && mresp.ar_ready,
            m == ro && mr_ar && mresp.r_valid};
      chk($sformatf("slv_ctl[%0d]", m), 64'({sresp[m].aw_ready,
          sresp[m].w_ready, sresp[m].b_valid, sresp[m].ar_ready,
          sresp[m].r_valid}), 64'(es));
      if (es[2]) chk("b_pay", 64'(sresp[m].b), 64'(mresp.b));
      if (es[0]) chk("r_pay", 64'(sresp[m].r), 64'(mresp.r));
    end
    if (sresp[1].aw_ready || sresp[1].w_ready || sresp[1].b_valid)
      m1_seen = 1;
    if (sreq[0].w_valid && !was[0]) begin
      if (sresp[0].w_ready) early_bad++;
      else early_blk++;
    end

    if (rst) begin
      mw_own = -1; mr_own = -1; mw_prio = 0; mr_prio = 0;
      for (int m = 0; m < N; m++) begin
        wa[m] = 0; ra[m] = 0; wv[m] = 0;
      end
      s_w = 0; s_b = 0; s_r = 0; s_rv = 0; w_hold = 0; r_hold = 0;
      return;
    end

    // model advance
    if (wo < 0) begin
      for (int m = 0; m < N; m++) req[m] = sreq[m].aw_valid;
      mw_own = rr(req, mw_prio);
      if (mw_own >= 0) begin
        gq_w.push_back(mw_own); mw_aw = 0; mw_w = 0;
      end
    end else if (!mw_aw) begin
      if (eawv && mresp.aw_ready) mw_aw = 1;
    end else if (!mw_w) begin
      if (ewv && mresp.w_ready && sreq[wo].w.last) mw_w = 1;
    end else if (mresp.b_valid && sreq[wo].b_ready) begin
      mw_prio = (wo + 1) % N; mw_own = -1;
    end
    if (ro < 0) begin
      for (int m = 0; m < N; m++) req[m] = sreq[m].ar_valid;
      mr_own = rr(req, mr_prio);
      if (mr_own >= 0) begin
        gq_r.push_back(mr_own); mr_ar = 0;
      end
    end else if (!mr_ar) begin
      if (earv && mresp.ar_ready) mr_ar = 1;
    end else if (mresp.r_valid && sreq[ro].r_ready && mresp.r.last) begin
      mr_prio = (ro + 1) % N; mr_own = -1;
    end

    // agent advance
    for (int m = 0; m < N; m++) begin
      if (sreq[m].aw_valid && sresp[m].aw_ready) was[m] = 1;
      if (sreq[m].w_valid && sresp[m].w_ready) begin
        wb[m]++; wv[m] = 0;
      end
      if (sreq[m].b_ready && sresp[m].b_valid) begin
        chk("b_id", 64'(sresp[m].b.id), 64'(m));
        b_cnt[m]++; wa[m] = 0;
      end
      if (sreq[m].ar_valid && sresp[m].ar_ready) ras[m] = 1;
      if (sreq[m].r_ready && sresp[m].r_valid) begin
        chk("r_beat", 64'({sresp[m].r.id, sresp[m].r.data,
            sresp[m].r.last}), 64'({4'(m), raddr[m] + 32'(rb[m]),
            rb[m] == rl[m]}));
        if (sresp[m].r.last) ra[m] = 0;
        rb[m]++; r_cnt[m]++;
      end
    end
    if (mreq.aw_valid && mresp.aw_ready) begin
      s_w = 1; s_wid = mreq.aw.id; s_wlen = int'(mreq.aw.len); s_wbeat = 0;
    end
    if (mreq.w_valid && mresp.w_ready) begin
      chk("w_beat", 64'({mreq.w.data[31:28], mreq.w.data[15:0],
          mreq.w.last}), 64'({s_wid, 16'(s_wbeat), s_wbeat == s_wlen}));
      if (mreq.w.last) s_b = 1;
      s_wbeat++;
    end
    if (mresp.b_valid && mreq.b_ready) begin
      s_b = 0; s_w = 0;
    end
    if (mreq.ar_valid && mresp.ar_ready) begin
      s_r = 1; s_rid = mreq.ar.id; s_raddr = mreq.ar.addr;
      s_rlen = int'(mreq.ar.len); s_rbeat = 0;
    end
    if (mresp.r_valid && mreq.r_ready) begin
      if (mresp.r.last) s_r = 0;
      s_rbeat++; s_rv = 0;
    end
    if (w_hold > 0) w_hold--;
    if (r_hold > 0) r_hold--;
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #4;
    sample();
  endtask

  function automatic bit idle();
    bit r;
    r = mw_own < 0 && mr_own < 0 && !s_w && !s_r;
    for (int m = 0; m < N; m++)
      if (wa[m] || ra[m] || wq[m].size() > 0 || rq[m].size() > 0) r = 0;
    return r;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    int c;
    c = 0;
    step();
    while (!idle() && c < budget) begin
      step(); c++;
    end
    chk({nm, "_done"}, 64'(idle()), 64'(1));
  endtask

  task automatic wait_wbeat(input int n);
    int c;
    c = 0;
    while (s_wbeat < n && c < 100) begin
      step(); c++;
    end
    chk("reach_wbeat", 64'(s_wbeat >= n), 64'(1));
  endtask

  task automatic do_reset();
    rst_cmd = 1; step(); step();
    rst_cmd = 0;
  endtask

  int b0 [N], r0 [N], exp_rb [N];

  initial begin
    n_chk = 0; n_fail = 0; rnd = 0; rst_cmd = 1;
    mw_own = -1; mr_own = -1; mw_prio = 0; mr_prio = 0;
    for (int m = 0; m < N; m++) begin
      wseq[m] = 0; b_cnt[m] = 0; r_cnt[m] = 0; raddr[m] = '0;
      wl[m] = 0; rl[m] = 0;
    end
    drive();
    @(posedge clk);
    do_reset();
    chk("reset_busy", 64'({wbusy, rbusy}), 64'(0));

    // single write, M1 quiet
    m1_seen = 0;
    wq[0].push_back(3);
    wait_idle("single", 100);
    chk("single_b", 64'(b_cnt[0]), 64'(1));
    chk("single_gnt", 64'(gq_w.size() == 1 && gq_w[0] == 0), 64'(1));
    chk("model_wr_prio", 64'(mw_prio), 64'(1));
    chk("m1_no_ready", 64'(m1_seen), 64'(0));

    // contention from reset
    do_reset();
    gq_w.delete();
    repeat (4) begin
      wq[0].push_back(0); wq[1].push_back(0);
      wait_idle("contend", 200);
    end
    chk("contend_n", 64'(gq_w.size()), 64'(8));
    for (int i = 0; i < 8; i++)
      chk($sformatf("contend_gnt%0d", i),
          64'(i < gq_w.size() ? gq_w[i] : -1), 64'(i % 2));

    // concurrent read and write
    for (int m = 0; m < N; m++) begin
      b0[m] = b_cnt[m]; r0[m] = r_cnt[m];
    end
    wq[0].push_back(0); rq[1].push_back(7);
    wait_idle("concur", 200);
    chk("concur_r1", 64'(r_cnt[1] - r0[1]), 64'(8));
    chk("concur_r0", 64'(r_cnt[0] - r0[0]), 64'(0));
    chk("concur_b0", 64'(b_cnt[0] - b0[0]), 64'(1));
    chk("concur_b1", 64'(b_cnt[1] - b0[1]), 64'(0));

    // backpressure mid-burst
    for (int m = 0; m < N; m++) begin
      b0[m] = b_cnt[m]; r0[m] = r_cnt[m];
    end
    wq[0].push_back(7); rq[1].push_back(7);
    wait_wbeat(2);
    w_hold = 5; r_hold = 4;
    wait_idle("bp", 300);
    chk("bp_b0", 64'(b_cnt[0] - b0[0]), 64'(1));
    chk("bp_r1", 64'(r_cnt[1] - r0[1]), 64'(8));

    // reset in the middle of a write burst
    wq[0].push_back(3);
    wait_wbeat(2);
    rst_cmd = 1; step();
    rst_cmd = 0; step();
    chk("rst_busy", 64'(wbusy), 64'(0));
    chk("rst_mctl", 64'({mreq.aw_valid, mreq.w_valid, mreq.b_ready}),
        64'(0));
    gq_w.delete();
    wq[1].push_back(0); wq[0].push_back(0);
    wait_idle("after_rst", 200);
    chk("rst_prio", 64'(gq_w.size() > 0 ? gq_w[0] : -1), 64'(0));

    // W presented before AW handshake
    b0[0] = b_cnt[0]; early_blk = 0; early_bad = 0;
    early_next[0] = 1;
    wq[0].push_back(1);
    wait_idle("early", 100);
    chk("early_blocked", 64'(early_blk > 0), 64'(1));
    chk("early_no_rdy", 64'(early_bad), 64'(0));
    chk("early_b", 64'(b_cnt[0] - b0[0]), 64'(1));

    // randomized traffic from every master
    rnd = 1;
    for (int m = 0; m < N; m++) begin
      b0[m] = b_cnt[m]; r0[m] = r_cnt[m]; exp_rb[m] = 0;
      repeat (12) begin
        int l;
        wq[m].push_back($urandom_range(0, 4));
        l = $urandom_range(0, 4);
        rq[m].push_back(l);
        exp_rb[m] += l + 1;
      end
    end
    wait_idle("rand", 30000);
    for (int m = 0; m < N; m++) begin
      chk($sformatf("rand_b%0d", m), 64'(b_cnt[m] - b0[m]), 64'(12));
      chk($sformatf("rand_r%0d", m), 64'(r_cnt[m] - r0[m]),
          64'(exp_rb[m]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
